// File: rtl/timestamp_pkg.sv
// Shared word-format constants and decoder state type for the timestamp FIFO consumer.
package timestamp_pkg;

    localparam logic [3:0] TS_TYPE_LO  = 4'h1;
    localparam logic [3:0] TS_TYPE_MID = 4'h2;
    localparam logic [3:0] TS_TYPE_HI  = 4'h3;

    localparam int unsigned ID_MSB      = 31;
    localparam int unsigned ID_LSB      = 28;
    localparam int unsigned TYPE_MSB    = 27;
    localparam int unsigned TYPE_LSB    = 24;
    localparam int unsigned PAYLOAD_MSB = 23;
    localparam int unsigned PAYLOAD_LSB = 0;
    localparam int unsigned HI_BITS     = 16;

    typedef enum logic [1:0] {
        WAIT_HI,
        WAIT_MID,
        WAIT_LO,
        OUT
    } ts_state_e;

endpackage

// File: rtl/timestamp_decoder_sat_counter.sv
// Up-counter with synchronous reset that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/timestamp_decoder.sv
// Pops tagged words from the timestamp FIFO, reassembles hi/mid/lo triples into
// 64-bit timestamps and streams them out with the delta to the previous one.
module timestamp_decoder
    import timestamp_pkg::*;
#(
    parameter logic [3:0]  IDENTIFIER    = 4'b0001,
    parameter int unsigned ERR_CNT_WIDTH = 8
) (
    input  logic                     BUS_CLK,
    input  logic                     BUS_RST,
    input  logic                     FIFO_EMPTY,
    output logic                     FIFO_READ,
    input  logic [31:0]              FIFO_DATA,
    output logic [63:0]              TS_DATA,
    output logic [63:0]              TS_DELTA,
    output logic                     TS_FIRST,
    output logic                     TS_VALID,
    input  logic                     TS_READY,
    output logic [31:0]              TS_CNT,
    output logic [ERR_CNT_WIDTH-1:0] SEQ_ERR_CNT,
    output logic [ERR_CNT_WIDTH-1:0] ID_ERR_CNT
);

    ts_state_e   state_q, state_d;
    logic        rd_pending_q;
    logic        fifo_read;
    logic [15:0] hi_q, hi_d;
    logic [23:0] mid_q, mid_d;
    logic [63:0] ts_data_q, ts_data_d;
    logic [63:0] ts_delta_q, ts_delta_d;
    logic [63:0] prev_ts_q, prev_ts_d;
    logic        ts_first_q, ts_first_d;
    logic        ts_valid_q, ts_valid_d;
    logic        prev_valid_q, prev_valid_d;
    logic [31:0] ts_cnt_q, ts_cnt_d;
    logic        seq_inc;
    logic        id_inc;

    logic [3:0]  word_id;
    logic [3:0]  word_type;
    logic [23:0] payload;
    logic [63:0] new_ts;

    assign word_id   = FIFO_DATA[ID_MSB:ID_LSB];
    assign word_type = FIFO_DATA[TYPE_MSB:TYPE_LSB];
    assign payload   = FIFO_DATA[PAYLOAD_MSB:PAYLOAD_LSB];
    assign new_ts    = {hi_q, mid_q, payload};

    // One word in flight at a time, and none while a timestamp waits for the sink.
    assign fifo_read = !FIFO_EMPTY && !rd_pending_q && (state_q != OUT) && !BUS_RST;

    always_comb begin
        state_d      = state_q;
        hi_d         = hi_q;
        mid_d        = mid_q;
        ts_data_d    = ts_data_q;
        ts_delta_d   = ts_delta_q;
        ts_first_d   = ts_first_q;
        ts_valid_d   = ts_valid_q;
        prev_ts_d    = prev_ts_q;
        prev_valid_d = prev_valid_q;
        ts_cnt_d     = ts_cnt_q;
        seq_inc      = 1'b0;
        id_inc       = 1'b0;

        if (rd_pending_q) begin
            if (word_id != IDENTIFIER) begin
                id_inc = 1'b1;
            end else begin
                case (state_q)
                    WAIT_HI: begin
                        if (word_type == TS_TYPE_HI) begin
                            hi_d    = payload[HI_BITS-1:0];
                            state_d = WAIT_MID;
                        end else begin
                            seq_inc = 1'b1;
                        end
                    end
                    WAIT_MID: begin
                        if (word_type == TS_TYPE_MID) begin
                            mid_d   = payload;
                            state_d = WAIT_LO;
                        end else if (word_type == TS_TYPE_HI) begin
                            seq_inc = 1'b1;
                            hi_d    = payload[HI_BITS-1:0];
                        end else begin
                            seq_inc = 1'b1;
                            state_d = WAIT_HI;
                        end
                    end
                    WAIT_LO: begin
                        if (word_type == TS_TYPE_LO) begin
                            ts_data_d  = new_ts;
                            ts_delta_d = prev_valid_q ? (new_ts - prev_ts_q) : '0;
                            ts_first_d = !prev_valid_q;
                            ts_valid_d = 1'b1;
                            state_d    = OUT;
                        end else if (word_type == TS_TYPE_HI) begin
                            seq_inc = 1'b1;
                            hi_d    = payload[HI_BITS-1:0];
                            state_d = WAIT_MID;
                        end else begin
                            seq_inc = 1'b1;
                            state_d = WAIT_HI;
                        end
                    end
                    default: ;
                endcase
            end
        end

        if ((state_q == OUT) && ts_valid_q && TS_READY) begin
            ts_valid_d   = 1'b0;
            prev_ts_d    = ts_data_q;
            prev_valid_d = 1'b1;
            ts_cnt_d     = ts_cnt_q + 32'd1;
            state_d      = WAIT_HI;
        end
    end

    always_ff @(posedge BUS_CLK) begin
        if (BUS_RST) begin
            state_q      <= WAIT_HI;
            rd_pending_q <= 1'b0;
            hi_q         <= '0;
            mid_q        <= '0;
            ts_data_q    <= '0;
            ts_delta_q   <= '0;
            ts_first_q   <= 1'b0;
            ts_valid_q   <= 1'b0;
            prev_ts_q    <= '0;
            prev_valid_q <= 1'b0;
            ts_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            rd_pending_q <= fifo_read;
            hi_q         <= hi_d;
            mid_q        <= mid_d;
            ts_data_q    <= ts_data_d;
            ts_delta_q   <= ts_delta_d;
            ts_first_q   <= ts_first_d;
            ts_valid_q   <= ts_valid_d;
            prev_ts_q    <= prev_ts_d;
            prev_valid_q <= prev_valid_d;
            ts_cnt_q     <= ts_cnt_d;
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_seq_err_cnt (
        .clk_i (BUS_CLK),
        .rst_i (BUS_RST),
        .inc_i (seq_inc),
        .cnt_o (SEQ_ERR_CNT)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_id_err_cnt (
        .clk_i (BUS_CLK),
        .rst_i (BUS_RST),
        .inc_i (id_inc),
        .cnt_o (ID_ERR_CNT)
    );

    assign FIFO_READ = fifo_read;
    assign TS_DATA   = ts_data_q;
    assign TS_DELTA  = ts_delta_q;
    assign TS_FIRST  = ts_first_q;
    assign TS_VALID  = ts_valid_q;
    assign TS_CNT    = ts_cnt_q;

endmodule

// File: tb/tb_timestamp_decoder.sv
// Bench for timestamp_decoder: frame table, directed corner sequences and a
// randomized word stream checked against a frame-level reference model.
module tb_timestamp_decoder;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST = 1'b1;
    logic        FIFO_EMPTY = 1'b1;
    logic        FIFO_READ;
    logic [31:0] FIFO_DATA = '0;
    logic [63:0] TS_DATA;
    logic [63:0] TS_DELTA;
    logic        TS_FIRST;
    logic        TS_VALID;
    logic        TS_READY = 1'b0;
    logic [31:0] TS_CNT;
    logic [7:0]  SEQ_ERR_CNT;
    logic [7:0]  ID_ERR_CNT;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [31:0] fifo_q[$];

    typedef struct {
        logic [31:0] w0, w1, w2;
        logic [63:0] ts;
        logic [63:0] delta;
        logic        first;
        logic [31:0] cnt;
    } vec_t;

    typedef struct {
        logic [63:0] ts;
        logic [63:0] delta;
        logic        first;
    } exp_t;

    exp_t        exp_q[$];
    bit          mon_en = 1'b0;
    int          m_part_n;
    logic [15:0] m_hi;
    logic [23:0] m_mid;
    logic [63:0] m_prev;
    bit          m_first;
    int          m_seq, m_id, m_frames;

    timestamp_decoder #(
        .IDENTIFIER    (4'b0001),
        .ERR_CNT_WIDTH (8)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST     (BUS_RST),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_READ   (FIFO_READ),
        .FIFO_DATA   (FIFO_DATA),
        .TS_DATA     (TS_DATA),
        .TS_DELTA    (TS_DELTA),
        .TS_FIRST    (TS_FIRST),
        .TS_VALID    (TS_VALID),
        .TS_READY    (TS_READY),
        .TS_CNT      (TS_CNT),
        .SEQ_ERR_CNT (SEQ_ERR_CNT),
        .ID_ERR_CNT  (ID_ERR_CNT)
    );

    always #5 BUS_CLK = ~BUS_CLK;

    // Upstream FIFO: a pop seen at the edge presents its word shortly after it.
    always begin : fifo_model
        bit fire;
        @(posedge BUS_CLK);
        fire = FIFO_READ;
        #1;
        if (fire && fifo_q.size() != 0) FIFO_DATA = fifo_q.pop_front();
        FIFO_EMPTY = (fifo_q.size() == 0);
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge BUS_CLK) begin : monitor
        exp_t e;
        if (mon_en && TS_VALID && TS_READY && !BUS_RST) begin
            if (exp_q.size() == 0) begin
                check("rnd_unexpected_ts", TS_DATA, 64'hX);
            end else begin
                e = exp_q.pop_front();
                check("rnd_data", TS_DATA, e.ts);
                check("rnd_delta", TS_DELTA, e.delta);
                check("rnd_first", {63'd0, TS_FIRST}, {63'd0, e.first});
            end
        end
    end

    task automatic model_reset();
        exp_q.delete();
        m_part_n = 0; m_hi = '0; m_mid = '0; m_prev = '0;
        m_first = 1'b1; m_seq = 0; m_id = 0; m_frames = 0;
    endtask

    // Frame-level view: a partial frame is the list of accepted words so far.
    task automatic model_word(input logic [31:0] w);
        logic [3:0]  t;
        logic [63:0] ts;
        exp_t        e;
        t = w[27:24];
        if (w[31:28] != 4'h1) begin
            m_id++;
        end else if (t == 4'h3) begin
            if (m_part_n != 0) m_seq++;
            m_hi = w[15:0];
            m_part_n = 1;
        end else if (t == 4'h2 && m_part_n == 1) begin
            m_mid = w[23:0];
            m_part_n = 2;
        end else if (t == 4'h1 && m_part_n == 2) begin
            ts = {m_hi, m_mid, w[23:0]};
            e.ts = ts;
            e.delta = m_first ? 64'd0 : ts - m_prev;
            e.first = m_first;
            exp_q.push_back(e);
            m_prev = ts;
            m_first = 1'b0;
            m_part_n = 0;
            m_frames++;
        end else begin
            m_seq++;
            m_part_n = 0;
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
    endtask

    task automatic push_frame(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        push_word(a); push_word(b); push_word(c);
    endtask

    task automatic do_reset();
        @(negedge BUS_CLK);
        BUS_RST = 1'b1;
        fifo_q.delete();
        repeat (3) @(negedge BUS_CLK);
        BUS_RST = 1'b0;
    endtask

    task automatic wait_valid(input int max_cyc, input string name);
        for (int i = 0; i < max_cyc && !TS_VALID; i++) @(negedge BUS_CLK);
        check({name, "_valid_timeout"}, {63'd0, TS_VALID}, 64'd1);
    endtask

    function automatic int sat255(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    vec_t vecs[4];

    initial begin
        logic [63:0] snap_data, snap_delta;
        logic        snap_first;
        bit          ok, seen;
        int          c;

        vecs[0] = '{32'h13000123, 32'h12456789, 32'h11ABCDEF, 64'h0123456789ABCDEF, 64'h0, 1'b1, 32'd1};
        vecs[1] = '{32'h13000123, 32'h12456789, 32'h11ABCE00, 64'h0123456789ABCE00, 64'h11, 1'b0, 32'd2};
        vecs[2] = '{32'h13FF0001, 32'h12000000, 32'h11000005, 64'h0001000000000005, 64'hFEDDBA9876543205, 1'b0, 32'd3};
        vecs[3] = '{32'h1300FFFF, 32'h12FFFFFF, 32'h11FFFFFF, 64'hFFFFFFFFFFFFFFFF, 64'hFFFEFFFFFFFFFFFA, 1'b0, 32'd4};

        // Reset state
        repeat (2) @(negedge BUS_CLK);
        check("rst_data", TS_DATA, 64'h0);
        check("rst_delta", TS_DELTA, 64'h0);
        check("rst_flags", {60'd0, TS_FIRST, TS_VALID, FIFO_READ, 1'b0}, 64'h0);
        check("rst_cnt", {32'd0, TS_CNT}, 64'h0);
        check("rst_errs", {48'd0, SEQ_ERR_CNT, ID_ERR_CNT}, 64'h0);
        BUS_RST = 1'b0;

        // Frame table with the sink always ready
        TS_READY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_frame(vecs[i].w0, vecs[i].w1, vecs[i].w2);
            wait_valid(40, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d_data", i), TS_DATA, vecs[i].ts);
            check($sformatf("tbl%0d_delta", i), TS_DELTA, vecs[i].delta);
            check($sformatf("tbl%0d_first", i), {63'd0, TS_FIRST}, {63'd0, vecs[i].first});
            @(negedge BUS_CLK);
            check($sformatf("tbl%0d_cnt", i), {32'd0, TS_CNT}, {32'd0, vecs[i].cnt});
            check($sformatf("tbl%0d_valid_drop", i), {63'd0, TS_VALID}, 64'd0);
        end

        // Backpressure with more words waiting in the FIFO
        TS_READY = 1'b0;
        push_frame(32'h13000123, 32'h12456789, 32'h11ABCF00);
        push_frame(32'h13000000, 32'h12000000, 32'h11000001);
        wait_valid(40, "bp");
        check("bp_data", TS_DATA, 64'h0123456789ABCF00);
        check("bp_delta", TS_DELTA, 64'h0123456789ABCF01);
        snap_data = TS_DATA; snap_delta = TS_DELTA; snap_first = TS_FIRST;
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge BUS_CLK);
            if (!TS_VALID || TS_DATA !== snap_data || TS_DELTA !== snap_delta ||
                TS_FIRST !== snap_first || FIFO_READ !== 1'b0 || FIFO_EMPTY !== 1'b0) ok = 1'b0;
        end
        check("bp_hold", {63'd0, ok}, 64'd1);
        check("bp_cnt_held", {32'd0, TS_CNT}, 64'd4);
        TS_READY = 1'b1;
        @(negedge BUS_CLK);
        TS_READY = 1'b0;
        check("bp_cnt_once", {32'd0, TS_CNT}, 64'd5);
        repeat (15) @(negedge BUS_CLK);
        check("bp_cnt_still", {32'd0, TS_CNT}, 64'd5);
        check("bp_next_data", TS_DATA, 64'h0000000000000001);
        check("bp_next_delta", TS_DELTA, 64'hFEDCBA9876543101);
        TS_READY = 1'b1;
        @(negedge BUS_CLK);
        check("bp_cnt_next", {32'd0, TS_CNT}, 64'd6);

        // Foreign-ID word inside a frame
        do_reset();
        push_frame(32'h13000123, 32'h12456789, 32'h2FFFFFFF);
        push_word(32'h11ABCDEF);
        wait_valid(40, "fid");
        check("fid_data", TS_DATA, 64'h0123456789ABCDEF);
        check("fid_first", {63'd0, TS_FIRST}, 64'd1);
        check("fid_delta", TS_DELTA, 64'h0);
        @(negedge BUS_CLK);
        check("fid_id_err", {56'd0, ID_ERR_CNT}, 64'd1);
        check("fid_seq_err", {56'd0, SEQ_ERR_CNT}, 64'd0);

        // Missing mid word
        do_reset();
        push_word(32'h13000123);
        push_word(32'h11ABCDEF);
        push_frame(32'h13000001, 32'h12000002, 32'h11000003);
        wait_valid(60, "mid");
        check("mid_data", TS_DATA, 64'h0001000002000003);
        check("mid_first", {63'd0, TS_FIRST}, 64'd1);
        repeat (10) @(negedge BUS_CLK);
        check("mid_cnt", {32'd0, TS_CNT}, 64'd1);
        check("mid_seq_err", {56'd0, SEQ_ERR_CNT}, 64'd1);
        check("mid_valid_low", {63'd0, TS_VALID}, 64'd0);

        // Reset lands on the cycle the type-2 word is being consumed
        do_reset();
        push_word(32'h13000123);
        push_word(32'h12456789);
        for (c = 0; c < 40 && fifo_q.size() != 0; c++) @(negedge BUS_CLK);
        check("rmf_popped", {63'd0, fifo_q.size() == 0}, 64'd1);
        BUS_RST = 1'b1;
        @(negedge BUS_CLK);
        BUS_RST = 1'b0;
        push_word(32'h11ABCDEF);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge BUS_CLK);
            if (TS_VALID) seen = 1'b1;
        end
        check("rmf_no_valid", {63'd0, seen}, 64'd0);
        check("rmf_seq_err", {56'd0, SEQ_ERR_CNT}, 64'd1);
        push_frame(32'h13000123, 32'h12456789, 32'h11ABCDEF);
        wait_valid(40, "rmf");
        check("rmf_data", TS_DATA, 64'h0123456789ABCDEF);
        check("rmf_first", {63'd0, TS_FIRST}, 64'd1);
        check("rmf_delta", TS_DELTA, 64'h0);

        // Sequence-error counter saturation
        do_reset();
        for (int i = 0; i < 300; i++) push_word(32'h11000000);
        for (c = 0; c < 1000 && fifo_q.size() != 0; c++) @(negedge BUS_CLK);
        repeat (6) @(negedge BUS_CLK);
        check("sat_seq_err", {56'd0, SEQ_ERR_CNT}, 64'd255);
        check("sat_cnt", {32'd0, TS_CNT}, 64'd0);

        // Randomized stream against the frame-level model
        do_reset();
        model_reset();
        TS_READY = 1'b0;
        for (int i = 0; i < 150; i++) begin
            logic [31:0] w;
            logic [63:0] ts;
            logic [3:0]  id;
            if ($urandom_range(0, 9) < 6) begin
                ts = {$urandom, $urandom};
                w = {8'h13, 8'($urandom), ts[63:48]}; push_word(w); model_word(w);
                w = {8'h12, ts[47:24]};               push_word(w); model_word(w);
                w = {8'h11, ts[23:0]};                push_word(w); model_word(w);
            end else begin
                id = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(2, 15)) : 4'h1;
                w = {id, 4'($urandom_range(0, 15)), 24'($urandom)};
                push_word(w); model_word(w);
            end
        end
        mon_en = 1'b1;
        for (c = 0; c < 8000 && (fifo_q.size() != 0 || exp_q.size() != 0); c++) begin
            @(posedge BUS_CLK);
            #1 TS_READY = ($urandom_range(0, 2) != 0);
        end
        @(posedge BUS_CLK);
        #1 TS_READY = 1'b1;
        repeat (10) @(negedge BUS_CLK);
        mon_en = 1'b0;
        check("rnd_drained", {32'd0, exp_q.size()}, 64'd0);
        check("rnd_cnt", {32'd0, TS_CNT}, {32'd0, m_frames});
        check("rnd_seq_err", {56'd0, SEQ_ERR_CNT}, {56'd0, 8'(sat255(m_seq))});
        check("rnd_id_err", {56'd0, ID_ERR_CNT}, {56'd0, 8'(sat255(m_id))});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
